// File: rtl/pc_stack.sv
// Program counter with absolute/relative branching, stall, and a hardware
// return-address stack for CALL/RET subroutine flow.
module pc_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}},
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              STALL,
  input  logic              PCI,
  input  logic              BRANCH,
  input  logic              BR_REL,
  input  logic              CALL,
  input  logic              RET,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [SP_W-1:0]   stack_depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL_DEPTH = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE     = {{(SP_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_r;
  logic [SP_W-1:0]   depth_r;
  logic              ovf_r;
  logic              unf_r;
  logic [ADDR_W-1:0] stack_mem_r [2**IDX_W];

  logic [ADDR_W-1:0] addr_nxt_s;
  logic [SP_W-1:0]   depth_nxt_s;
  logic              ovf_nxt_s;
  logic              unf_nxt_s;
  logic              push_s;
  logic              full_s;
  logic              empty_s;
  logic [IDX_W-1:0]  push_idx_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic [ADDR_W-1:0] ret_addr_s;

  assign full_s     = (depth_r == FULL_DEPTH);
  assign empty_s    = (depth_r == {SP_W{1'b0}});
  assign push_idx_s = depth_r[IDX_W-1:0];
  assign top_idx_s  = depth_r[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
  assign ret_addr_s = addr_r + ADDR_ONE;

  // Next-state selection: stall freezes everything, else RET > CALL > BRANCH > PCI.
  always_comb begin
    addr_nxt_s  = addr_r;
    depth_nxt_s = depth_r;
    ovf_nxt_s   = ovf_r;
    unf_nxt_s   = unf_r;
    push_s      = 1'b0;
    if (STALL) begin
      addr_nxt_s = addr_r;
    end else if (RET) begin
      if (!empty_s) begin
        addr_nxt_s  = stack_mem_r[top_idx_s];
        depth_nxt_s = depth_r - SP_ONE;
      end else begin
        unf_nxt_s = 1'b1;
      end
    end else if (CALL) begin
      if (!full_s) begin
        push_s      = 1'b1;
        addr_nxt_s  = addr_in;
        depth_nxt_s = depth_r + SP_ONE;
      end else begin
        ovf_nxt_s = 1'b1;
      end
    end else if (BRANCH) begin
      // Same-width two's-complement add equals sign-extend-then-truncate.
      if (BR_REL) begin
        addr_nxt_s = addr_r + addr_in;
      end else begin
        addr_nxt_s = addr_in;
      end
    end else if (PCI) begin
      addr_nxt_s = addr_r + ADDR_ONE;
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      addr_r  <= RESET_ADDR;
      depth_r <= {SP_W{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      addr_r  <= addr_nxt_s;
      depth_r <= depth_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Return-address storage; contents need no reset since depth gates visibility.
  always_ff @(posedge clk) begin
    if (!RST && push_s) begin
      stack_mem_r[push_idx_s] <= ret_addr_s;
    end
  end

  assign addr_out    = addr_r;
  assign stack_depth = depth_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign stack_ovf   = ovf_r;
  assign stack_unf   = unf_r;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: directed commands push expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pc_stack;

  logic       clk;
  logic       RST, STALL, PCI, BRANCH, BR_REL, CALL, RET;
  logic [7:0] addr_in;
  logic [7:0] addr_out;
  logic [2:0] stack_depth;
  logic       stack_full, stack_empty, stack_ovf, stack_unf;

  typedef struct packed {
    logic [7:0] addr;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } state_t;

  state_t exp_q [$];
  string  name_q [$];
  int     checks = 0;
  int     errors = 0;

  pc_stack #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .RST(RST), .STALL(STALL), .PCI(PCI), .BRANCH(BRANCH),
    .BR_REL(BR_REL), .CALL(CALL), .RET(RET), .addr_in(addr_in),
    .addr_out(addr_out), .stack_depth(stack_depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command cycle and queue the state expected after the edge.
  task automatic step(input string nm, input logic rst, input logic stall,
                      input logic ret, input logic call, input logic br,
                      input logic rel, input logic pci, input logic [7:0] ain,
                      input logic [7:0] e_addr, input logic [2:0] e_depth,
                      input logic e_ovf, input logic e_unf);
    state_t e;
    RST = rst; STALL = stall; RET = ret; CALL = call;
    BRANCH = br; BR_REL = rel; PCI = pci; addr_in = ain;
    @(posedge clk);
    e.addr  = e_addr;
    e.depth = e_depth;
    e.full  = (e_depth == 3'd4);
    e.empty = (e_depth == 3'd0);
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  // Monitor: compare DUT state against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      state_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {addr_out, stack_depth, stack_full, stack_empty, stack_ovf, stack_unf};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got addr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want addr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                 nm, a.addr, a.depth, a.full, a.empty, a.ovf, a.unf,
                 e.addr, e.depth, e.full, e.empty, e.ovf, e.unf);
      end
    end
  end

  initial begin
    RST = 1'b0; STALL = 1'b0; PCI = 1'b0; BRANCH = 1'b0; BR_REL = 1'b0;
    CALL = 1'b0; RET = 1'b0; addr_in = 8'h00;
    @(negedge clk);
    //        name          rst  stl  ret  call br   rel  pci  ain     addr   dep   ovf  unf
    step("reset",       1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,3'd0,1'b0,1'b0);
    step("pci1",        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h01,3'd0,1'b0,1'b0);
    step("pci2",        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h02,3'd0,1'b0,1'b0);
    step("pci3",        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h03,3'd0,1'b0,1'b0);
    step("br_ff",       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'hFF, 8'hFF,3'd0,1'b0,1'b0);
    step("pci_wrap",    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h00,3'd0,1'b0,1'b0);
    step("br_10",       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h10, 8'h10,3'd0,1'b0,1'b0);
    step("br_abs40",    1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h40, 8'h40,3'd0,1'b0,1'b0);
    step("br_rel_m4",   1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'hFC, 8'h3C,3'd0,1'b0,1'b0);
    step("br_rel_p5",   1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h05, 8'h41,3'd0,1'b0,1'b0);
    step("br_pci_pri",  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'hF0, 8'hF0,3'd0,1'b0,1'b0);
    step("br_rel_wrap", 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h20, 8'h10,3'd0,1'b0,1'b0);
    step("br_20",       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h20, 8'h20,3'd0,1'b0,1'b0);
    step("call_80",     1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h80, 8'h80,3'd1,1'b0,1'b0);
    step("call_a0",     1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA0, 8'hA0,3'd2,1'b0,1'b0);
    step("ret_81",      1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h81,3'd1,1'b0,1'b0);
    step("ret_21",      1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h21,3'd0,1'b0,1'b0);
    step("hold",        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h55, 8'h21,3'd0,1'b0,1'b0);
    step("fill1",       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h10, 8'h10,3'd1,1'b0,1'b0);
    step("fill2",       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h20, 8'h20,3'd2,1'b0,1'b0);
    step("fill3_rel",   1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h30, 8'h30,3'd3,1'b0,1'b0);
    step("fill4",       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h40, 8'h40,3'd4,1'b0,1'b0);
    step("call_ovf",    1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h50, 8'h40,3'd4,1'b1,1'b0);
    step("stall_ret",   1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h40,3'd4,1'b1,1'b0);
    step("pop4",        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h31,3'd3,1'b1,1'b0);
    step("pop3",        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h21,3'd2,1'b1,1'b0);
    step("pop2",        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h11,3'd1,1'b1,1'b0);
    step("pri_ret",     1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,8'h77, 8'h22,3'd0,1'b1,1'b0);
    step("ret_unf",     1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h22,3'd0,1'b1,1'b1);
    step("flags_stick", 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h23,3'd0,1'b1,1'b1);
    step("stall_call",  1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h77, 8'h23,3'd0,1'b1,1'b1);
    step("mid_call1",   1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h60, 8'h60,3'd1,1'b1,1'b1);
    step("mid_call2",   1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h61, 8'h61,3'd2,1'b1,1'b1);
    step("mid_call3",   1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h62, 8'h62,3'd3,1'b1,1'b1);
    step("rst_call",    1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h99, 8'h00,3'd0,1'b0,1'b0);
    step("post_rst_unf",1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,3'd0,1'b0,1'b1);
    step("call_05",     1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h05, 8'h05,3'd1,1'b0,1'b1);
    step("ret_01",      1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h01,3'd0,1'b0,1'b1);
    RET = 1'b0; CALL = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
Parametrised program counter for the downsampling processor's control unit, succeeding the fixed 8-bit PC. It adds absolute and relative branching, a stall input, and a hardware return-address stack for CALL/RET subroutine flow. It sits between the control unit (PCI/BRANCH/CALL/RET/STALL) and the instruction memory address port (addr_out).

Parameters:
ADDR_W, 8, width of program address and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, value loaded into addr_out on reset
(localparam SP_W = clog2(STACK_DEPTH+1), width of the depth counter)

Ports:
clk  input  1  clock; all state updates on rising edge
RST  input  1  reset
STALL  input  1  freeze PC and stack this cycle
PCI  input  1  increment PC by 1
BRANCH  input  1  load branch target
BR_REL  input  1  with BRANCH: 0 = absolute (addr_in), 1 = relative (addr_out + signed addr_in)
CALL  input  1  push return address, jump to addr_in
RET  input  1  pop return address into PC
addr_in  input  ADDR_W  branch/call target or signed offset
addr_out  output  ADDR_W  current instruction address
stack_depth  output  SP_W  number of valid stack entries
stack_full  output  1  stack_depth == STACK_DEPTH (combinational from state)
stack_empty  output  1  stack_depth == 0 (combinational from state)
stack_ovf  output  1  sticky: CALL attempted while full
stack_unf  output  1  sticky: RET attempted while empty

Behaviour:
- One clock domain. Reset is synchronous and active-high: RST sampled on rising edge of clk.
- RST=1 (highest priority, overrides STALL and all commands): addr_out<=RESET_ADDR, stack_depth<=0, stack_ovf<=0, stack_unf<=0; stack storage contents don't-care. After reset: stack_empty=1, stack_full=0.
- STALL=1 (RST=0): addr_out, stack contents, stack_depth, sticky flags all hold; all commands ignored, no flags set.
- Otherwise exactly one action per cycle, priority RET > CALL > BRANCH > PCI > hold. Lower-priority commands asserted in the same cycle are ignored silently.
- RET, depth>0: addr_out<=stack[depth-1]; depth<=depth-1.
- RET, depth==0: addr_out holds; stack_unf<=1.
- CALL, depth<STACK_DEPTH: stack[depth]<=addr_out+1 (mod 2^ADDR_W); depth<=depth+1; addr_out<=addr_in (always absolute, BR_REL ignored).
- CALL, depth==STACK_DEPTH: no push, addr_out holds; stack_ovf<=1.
- BRANCH, BR_REL=0: addr_out<=addr_in.
- BRANCH, BR_REL=1: addr_out<=addr_out + sign-extended addr_in, truncated to ADDR_W (two's-complement wrap).
- PCI: addr_out<=addr_out+1, wraps all-ones -> 0.
- No command: all state holds.
- Latency: every update visible on addr_out the cycle after the command edge; no combinational path from any input to addr_out.
- Sticky flags clear only on RST.
- Stack is LIFO; entries above depth are unobservable.

Test Plan:
- Reset/increment: RST=1 one cycle, then PCI=1 x3 -> addr_out 0x00,0x01,0x02,0x03; depth=0, empty=1; PCI at 0xFF -> 0x00.
- Branches: addr_out=0x10, BRANCH=1,BR_REL=0,addr_in=0x40 -> 0x40; then BR_REL=1,addr_in=0xFC -> 0x3C; BR_REL=1,addr_in=0x05 -> 0x41.
- Nested call/return: at 0x20 CALL addr_in=0x80; at 0x80 CALL addr_in=0xA0 -> depth=2; RET -> 0x81; RET -> 0x21; depth=0, no flags.
- Overflow/underflow: 4 CALLs -> full=1; 5th CALL -> addr_out holds, stack_ovf=1, depth=4; empty stack + RET -> addr_out holds, stack_unf=1; flags persist until RST.
- Priority/stall: CALL+RET+PCI together with depth=1 -> pop only, depth=0; STALL=1 with CALL -> nothing changes for that cycle.
- Reset mid-operation: depth=3, RST asserted with CALL -> addr_out=RESET_ADDR, depth=0, flags 0; subsequent RET sets stack_unf.
